// File: rtl/cla_accumulator_pkg.sv
// Shared definitions for the CLA accumulator: FSM encoding and default widths.
// The CLA bench uses the same width constants.
package cla_accumulator_pkg;

   localparam int CLA_WIDTH   = 16;
   localparam int CLA_COUNT_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/cla_accumulator_cla.sv
// Team carry-lookahead adder (Z, C1, A, B, C): 4-bit lookahead groups chained by group
// generate/propagate terms. WIDTH must be a multiple of 4.
module cla_accumulator_cla
   import cla_accumulator_pkg::*;
#(
   parameter int WIDTH = CLA_WIDTH
) (
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             C,
   output logic [WIDTH-1:0] Z,
   output logic             C1
);

   localparam int GROUPS = WIDTH / 4;

   logic [WIDTH-1:0]  g;
   logic [WIDTH-1:0]  p;
   logic [WIDTH-1:0]  c;
   logic [GROUPS-1:0] gg;
   logic [GROUPS-1:0] gp;
   logic [GROUPS:0]   gc;

   assign g = A & B;
   assign p = A ^ B;

   // Group carries come from group G/P only; bit carries inside a group use only the group carry-in.
   always_comb begin
      gg    = '0;
      gp    = '0;
      gc    = '0;
      c     = '0;
      gc[0] = C;
      for (int k = 0; k < GROUPS; k++) begin
         gg[k] = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
         gp[k] = p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k];
         gc[k+1] = gg[k] | (gp[k] & gc[k]);
         c[4*k]   = gc[k];
         c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
         c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
         c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                  | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
      end
   end

   assign Z  = p ^ c;
   assign C1 = gc[GROUPS];

endmodule

// File: rtl/cla_accumulator.sv
// Burst accumulator: sums a length-tagged burst one operand per cycle through a single CLA
// and presents the registered sum plus carry statistics over a valid/ready output.
module cla_accumulator
   import cla_accumulator_pkg::*;
#(
   parameter int WIDTH   = CLA_WIDTH,
   parameter int COUNT_W = CLA_COUNT_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [COUNT_W-1:0] count,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_sum,
   output logic               out_carry,
   output logic [COUNT_W-1:0] carry_cnt
);

   state_t             state;
   state_t             next_state;
   logic [WIDTH-1:0]   acc;
   logic [WIDTH-1:0]   cla_sum;
   logic               cla_carry;
   logic [COUNT_W-1:0] remaining;
   logic               carry_sticky;
   logic [COUNT_W-1:0] carry_total;

   cla_accumulator_cla #(.WIDTH(WIDTH)) u_cla (
      .A  (acc),
      .B  (in_data),
      .C  (1'b0),
      .Z  (cla_sum),
      .C1 (cla_carry)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state)
         IDLE: begin
            if (start) next_state = (count == '0) ? DONE : ACCUM;
         end
         ACCUM: begin
            in_ready = 1'b1;
            if (in_valid && remaining == COUNT_W'(1)) next_state = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Accumulator and carry statistics only change on start in IDLE or an accepted beat in ACCUM.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc          <= '0;
         remaining    <= '0;
         carry_sticky <= 1'b0;
         carry_total  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  acc          <= '0;
                  remaining    <= count;
                  carry_sticky <= 1'b0;
                  carry_total  <= '0;
               end
            end
            ACCUM: begin
               if (in_valid) begin
                  acc          <= cla_sum;
                  remaining    <= remaining - COUNT_W'(1);
                  carry_sticky <= carry_sticky | cla_carry;
                  if (cla_carry && carry_total != '1) carry_total <= carry_total + COUNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign out_sum   = acc;
   assign out_carry = carry_sticky;
   assign carry_cnt = carry_total;

endmodule

// File: tb/tb_cla_accumulator.sv
// Scoreboard bench for cla_accumulator: expected burst results are modelled when each burst
// is driven and compared when the accumulator presents its result.
module tb_cla_accumulator;
   import cla_accumulator_pkg::*;

   localparam int W  = CLA_WIDTH;
   localparam int CW = CLA_COUNT_W;

   typedef struct {
      logic [W-1:0]  sum;
      logic          carry;
      logic [CW-1:0] cnt;
   } result_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [CW-1:0] count;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_data;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_sum;
   logic          out_carry;
   logic [CW-1:0] carry_cnt;

   result_t      exp_q[$];
   logic [W-1:0] beat_q[$];
   int           checks = 0;
   int           passed = 0;

   cla_accumulator dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .count     (count),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_carry (out_carry),
      .carry_cnt (carry_cnt)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed === expected) passed++;
      else $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
   endtask

   // Models the burst in beat_q, then drives start/count and the beats, with an optional in_valid gap.
   task automatic applyStimulus(input int n, input int gap_at, input int gap_len);
      result_t       r;
      logic [W:0]    s;
      r.sum   = '0;
      r.carry = 1'b0;
      r.cnt   = '0;
      for (int i = 0; i < n; i++) begin
         s     = {1'b0, r.sum} + {1'b0, beat_q[i]};
         r.sum = s[W-1:0];
         if (s[W]) begin
            r.carry = 1'b1;
            if (r.cnt != '1) r.cnt = r.cnt + 1'b1;
         end
      end
      exp_q.push_back(r);
      @(posedge clk); #1;
      start = 1'b1;
      count = CW'(n);
      @(posedge clk); #1;
      start = 1'b0;
      if (n == 0) begin
         @(negedge clk);
         checkOutput("zero_done_valid", 32'(out_valid), 32'd1);
         checkOutput("zero_in_ready", 32'(in_ready), 32'd0);
         return;
      end
      for (int i = 0; i < n; i++) begin
         if (i == gap_at) begin
            in_valid = 1'b0;
            repeat (gap_len) @(posedge clk);
            #1;
         end
         in_valid = 1'b1;
         in_data  = beat_q[i];
         @(negedge clk);
         checkOutput("in_ready", 32'(in_ready), 32'd1);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      in_data  = '0;
      @(negedge clk);
      checkOutput("latency_valid", 32'(out_valid), 32'd1);
   endtask

   // Waits for the result, holds out_ready low for 'hold' cycles, then completes the handshake.
   task automatic collectResult(input int hold, input bit junk, input bit start_at_hs);
      result_t e;
      int      guard = 0;
      out_ready = 1'b0;
      @(negedge clk);
      while (!out_valid && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      checkOutput("out_valid_wait", 32'(out_valid), 32'd1);
      if (exp_q.size() == 0) begin
         checkOutput("scoreboard_underflow", 32'(exp_q.size()), 32'd1);
         return;
      end
      e = exp_q.pop_front();
      checkOutput("out_sum", 32'(out_sum), 32'(e.sum));
      checkOutput("out_carry", 32'(out_carry), 32'(e.carry));
      checkOutput("carry_cnt", 32'(carry_cnt), 32'(e.cnt));
      if (junk) begin
         in_valid = 1'b1;
         in_data  = 16'hFFFF;
      end
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         checkOutput("hold_valid", 32'(out_valid), 32'd1);
         checkOutput("hold_sum", 32'(out_sum), 32'(e.sum));
         checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      if (start_at_hs) begin
         start = 1'b1;
         count = CW'(3);
      end
      @(posedge clk); #1;
      out_ready = 1'b0;
      start     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      @(negedge clk);
      checkOutput("post_hs_valid", 32'(out_valid), 32'd0);
      checkOutput("post_hs_in_ready", 32'(in_ready), 32'd0);
   endtask

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      count     = '0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
      checkOutput("rst_out_sum", 32'(out_sum), 32'd0);
      checkOutput("rst_out_carry", 32'(out_carry), 32'd0);
      checkOutput("rst_carry_cnt", 32'(carry_cnt), 32'd0);
      rst = 1'b0;

      beat_q = '{16'h0003, 16'h0008};
      applyStimulus(2, -1, 0);
      collectResult(0, 1'b0, 1'b0);

      beat_q = '{16'h0103};
      applyStimulus(1, -1, 0);
      collectResult(0, 1'b0, 1'b0);
      beat_q = '{16'h0103, 16'h0103};
      applyStimulus(2, -1, 0);
      collectResult(0, 1'b0, 1'b1);

      beat_q = '{16'hFFFF, 16'h0002, 16'hFFFF};
      applyStimulus(3, -1, 0);
      collectResult(0, 1'b0, 1'b0);

      beat_q.delete();
      applyStimulus(0, -1, 0);
      collectResult(0, 1'b0, 1'b0);

      beat_q = '{16'h1405, 16'h1809};
      applyStimulus(2, 1, 3);
      collectResult(5, 1'b1, 1'b0);

      // Abort a burst after one of three beats; everything must clear asynchronously.
      @(posedge clk); #1;
      start = 1'b1;
      count = CW'(3);
      @(posedge clk); #1;
      start    = 1'b0;
      in_valid = 1'b1;
      in_data  = 16'h1111;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = '0;
      rst      = 1'b1;
      #1;
      checkOutput("abort_out_sum", 32'(out_sum), 32'd0);
      checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
      checkOutput("abort_in_ready", 32'(in_ready), 32'd0);
      checkOutput("abort_out_carry", 32'(out_carry), 32'd0);
      checkOutput("abort_carry_cnt", 32'(carry_cnt), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      beat_q = '{16'h100D};
      applyStimulus(1, -1, 0);
      collectResult(0, 1'b0, 1'b0);

      checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, checks);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
